// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS fetch unit
//
// Purpose: fetch FSM state encoding, instruction width, PC increment and
//          the word-offset mask used to align redirect targets.
// Ports:   none (package).
package mips_pkg;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,  // no request outstanding
        FS_REQ     = 2'd1,  // request outstanding, returned word is kept
        FS_DISCARD = 2'd2   // request outstanding, returned word is dropped
    } fetch_state_t;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned PC_INCR     = 4;

    // Byte-offset bits inside a word; an address ANDed with the inverse of
    // this mask is word aligned.
    localparam logic [1:0] WORD_OFFSET_MASK = 2'b11;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO buffering fetched {instr, pc} entries
//
// Purpose: DEPTH-entry circular buffer with push, pop and flush; flush wins
//          over push and pop in the same cycle.
// Ports:   clk, nrst        - clock, async active-low reset
//          push, wdata      - write an entry (ignored when full without pop)
//          pop              - drop the head entry (ignored when empty)
//          flush            - empty the buffer
//          rdata, valid     - head entry and its validity
//          count            - number of stored entries
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - decoupled MIPS instruction fetch stage
//
// Purpose: issues word fetches over a req/ack handshake to a variable-latency
//          instruction memory, buffers returned words and hands
//          {instr, pc, pc+4} to decode over valid/ready. Redirects flush the
//          buffer and squash any in-flight fetch.
// Ports:   clk, nrst                    - clock, async active-low reset
//          redirect_valid, redirect_pc  - taken branch/jump target
//          imem_req, imem_addr          - fetch request and word address
//          imem_ack, imem_rdata         - fetch completion and instruction
//          out_valid, out_ready         - decode handshake
//          out_instr, out_pc, out_pc_plus4 - head instruction and its pcs
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = DATA_WIDTH + ADDR_WIDTH;

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] discard_addr;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  push;
    logic                  pop;
    logic                  space;
    logic                  head_valid;
    logic [EW-1:0]         head_data;
    logic [ADDR_WIDTH-1:0] head_pc;

    assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(WORD_OFFSET_MASK);

    // Only words returned in REQ without a concurrent redirect are kept.
    assign push = (state == FS_REQ) && imem_ack && !redirect_valid;
    assign pop  = head_valid && out_ready;

    // Occupancy after this cycle's push/pop/flush decides whether a new
    // request may start, so an acked word always finds a free slot.
    always_comb begin
        count_next = count;
        if (redirect_valid) count_next = '0;
        else                count_next = count + CW'(push) - CW'(pop);
    end
    assign space = (count_next < CW'(DEPTH));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= FS_IDLE;
            fetch_pc     <= RESET_PC;
            discard_addr <= RESET_PC;
        end else begin
            case (state)
                FS_IDLE: begin
                    if (redirect_valid) fetch_pc <= redirect_aligned;
                    if (space) state <= FS_REQ;
                end
                FS_REQ: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_aligned;
                        // Unacked request must be completed at its old address.
                        if (!imem_ack) begin
                            state        <= FS_DISCARD;
                            discard_addr <= fetch_pc;
                        end
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_INCR);
                        if (!space) state <= FS_IDLE;
                    end
                end
                FS_DISCARD: begin
                    if (redirect_valid) fetch_pc <= redirect_aligned;
                    if (imem_ack) state <= FS_REQ;
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

    assign imem_req  = (state != FS_IDLE);
    assign imem_addr = (state == FS_DISCARD) ? discard_addr : fetch_pc;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({imem_rdata, fetch_pc}),
        .rdata (head_data),
        .valid (head_valid),
        .count (count)
    );

    // Payload is gated so an empty buffer presents zeros, not stale entries.
    assign head_pc      = head_data[ADDR_WIDTH-1:0];
    assign out_valid    = head_valid;
    assign out_instr    = head_valid ? head_data[EW-1:ADDR_WIDTH] : '0;
    assign out_pc       = head_valid ? head_pc : '0;
    assign out_pc_plus4 = head_valid ? head_pc + ADDR_WIDTH'(PC_INCR) : '0;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - directed self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        nrst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    int errors = 0;
    int checks = 0;

    mips_fetch_unit dut (
        .clk            (clk),
        .nrst           (nrst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic do_reset();
        redirect_valid = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0; out_ready = 0;
        nrst = 0;
        repeat (2) @(negedge clk);
        nrst = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        redirect_valid = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0; out_ready = 0;
        nrst = 0;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
        checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", out_pc_plus4); end
        nrst = 1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req got=%0h exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL release_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            checks++; if (imem_addr !== a) begin errors++; $display("FAIL zw_addr%0d got=%h exp=%h", i, imem_addr, a); end
            imem_ack = 1; imem_rdata = imem_addr ^ K;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zw_valid%0d got=%0h exp=1", i, out_valid); end
            checks++; if (out_instr !== (a ^ K)) begin errors++; $display("FAIL zw_instr%0d got=%h exp=%h", i, out_instr, a ^ K); end
            checks++; if (out_pc !== a) begin errors++; $display("FAIL zw_pc%0d got=%h exp=%h", i, out_pc, a); end
            checks++; if (out_pc_plus4 !== a + 4) begin errors++; $display("FAIL zw_pc4%0d got=%h exp=%h", i, out_pc_plus4, a + 4); end
        end
        imem_ack = 0;
    endtask

    task automatic test_backpressure();
        int acks;
        do_reset();
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            imem_ack = imem_req; imem_rdata = imem_addr ^ K;
            if (imem_req) acks++;
            @(negedge clk);
        end
        imem_ack = 0;
        checks++; if (acks !== 4) begin errors++; $display("FAIL bp_acks got=%0d exp=4", acks); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_idle got=%0h exp=0", imem_req); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%0h exp=1", out_valid); end
        checks++; if (out_instr !== K) begin errors++; $display("FAIL bp_head_instr got=%h exp=%h", out_instr, K); end
        out_ready = 1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_req_again got=%0h exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL bp_addr got=%h exp=10", imem_addr); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (out_pc !== 32'(i * 4)) begin errors++; $display("FAIL bp_order%0d got=%h exp=%h", i, out_pc, 32'(i * 4)); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0h exp=0", out_valid); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL bp_hold_addr got=%h exp=10", imem_addr); end
    endtask

    task automatic test_delayed_redirect();
        do_reset();
        out_ready = 1;
        repeat (2) begin
            imem_ack = 1; imem_rdata = imem_addr ^ K;
            @(negedge clk);
        end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL dr_start_addr got=%h exp=8", imem_addr); end
        imem_ack = 0; redirect_valid = 1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dr_flush got=%0h exp=0", out_valid); end
        for (int c = 1; c <= 3; c++) begin
            checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL dr_hold%0d got=%h exp=8", c, imem_addr); end
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL dr_req%0d got=%0h exp=1", c, imem_req); end
            if (c == 3) begin imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; end
            @(negedge clk);
        end
        imem_ack = 0;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL dr_new_addr got=%h exp=100", imem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dr_dropped got=%0h exp=0", out_valid); end
        imem_ack = 1; imem_rdata = 32'h100 ^ K;
        @(negedge clk);
        imem_ack = 0;
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL dr_out_pc got=%h exp=100", out_pc); end
        checks++; if (out_instr !== (32'h100 ^ K)) begin errors++; $display("FAIL dr_out_instr got=%h exp=%h", out_instr, 32'h100 ^ K); end
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        out_ready = 1;
        imem_ack = 1; imem_rdata = 32'h0 ^ K;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL rap_head got=%0h/%h exp=1/0", out_valid, out_pc); end
        imem_ack = 1; imem_rdata = 32'h4 ^ K; redirect_valid = 1; redirect_pc = 32'h200;
        @(negedge clk);
        imem_ack = 0; redirect_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rap_empty got=%0h exp=0", out_valid); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rap_addr got=%h exp=200", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rap_req got=%0h exp=1", imem_req); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rap_still_empty got=%0h exp=0", out_valid); end
    endtask

    task automatic test_align_wrap();
        do_reset();
        out_ready = 1;
        imem_ack = 1; imem_rdata = K; redirect_valid = 1; redirect_pc = 32'h103;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL align_addr got=%h exp=100", imem_addr); end
        imem_ack = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
        imem_ack = 1; imem_rdata = imem_addr ^ K;
        @(negedge clk);
        imem_ack = 0;
        checks++; if (out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got=%h exp=fffffffc", out_pc); end
        checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=0", out_pc_plus4); end
        checks++; if (out_instr !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_instr got=%h exp=5a5afffc", out_instr); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=0", imem_addr); end
        out_ready = 0;
        #2 nrst = 0;
        #1;
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL async_rst got=%0h/%0h exp=0/0", imem_req, out_valid); end
        @(negedge clk);
        nrst = 1;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_delayed_redirect();
        test_redirect_ack_pop();
        test_align_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
